// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the Galois LFSR pattern generator (same POLY).
// Define LFSR_CHECKER_BITCNT_EN to add bit_cnt, a count of bits checked while locked.
module lfsr_checker #(
    parameter int unsigned W        = 8,
    parameter logic [W:0]  POLY     = 9'h11D,
    parameter int unsigned SYNC_CNT = 16,
    parameter int unsigned WIN      = 64,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned CW       = 32
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    input  logic          in,
    input  logic          clr_cnt,
    output logic          locked,
    output logic          err,
`ifdef LFSR_CHECKER_BITCNT_EN
    output logic [CW-1:0] bit_cnt,
`endif
    output logic [CW-1:0] err_cnt
);

    localparam int unsigned FW = $clog2(W + 1);

    typedef enum logic [1:0] {StFill, StSearch, StLock} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  h_q, h_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [7:0]    match_q, match_d;
    logic [15:0]   win_q, win_d;
    logic [15:0]   win_err_q, win_err_d;
    logic          err_q, err_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          p;
    logic          miss;

    // h[k-1] holds y[m-k], so POLY[k] lines up with h[k-1].
    assign p    = ^(POLY[W:1] & h_q);
    assign miss = in ^ p;

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        win_err_d = win_err_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (en) begin
            unique case (state_q)
                StFill: begin
                    h_d = {h_q[W-2:0], in};
                    if (fill_q == FW'(W - 1)) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = StSearch;
                    end else begin
                        fill_d = fill_q + FW'(1);
                    end
                end
                StSearch: begin
                    h_d = {h_q[W-2:0], in};
                    // All-zero history predicts zeros forever; never count it toward lock.
                    if ((h_q == '0) || miss) begin
                        match_d = '0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                    if (match_d == 8'(SYNC_CNT)) begin
                        state_d   = StLock;
                        match_d   = '0;
                        win_d     = '0;
                        win_err_d = '0;
                    end
                end
                StLock: begin
                    // Flywheel: feed back the prediction so line errors do not propagate.
                    h_d   = {h_q[W-2:0], p};
                    err_d = miss;
                    if (miss && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CW'(1);
                    end
                    win_d     = win_q + 16'd1;
                    win_err_d = win_err_q + 16'(miss);
                    if (win_err_d == 16'(LOSS_THR)) begin
                        state_d   = StFill;
                        fill_d    = '0;
                        win_d     = '0;
                        win_err_d = '0;
                    end else if (win_d == 16'(WIN)) begin
                        win_d     = '0;
                        win_err_d = '0;
                    end
                end
                default: state_d = StFill;
            endcase
        end
        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= StFill;
            h_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            win_err_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            win_err_q <= win_err_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = (state_q == StLock);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

`ifdef LFSR_CHECKER_BITCNT_EN
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (en && (state_q == StLock) && (bit_cnt_q != '1)) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
        end
        if (clr_cnt) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus queues expected err pulses and lock edges,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_lfsr_checker;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic arst = 1'b0;
    logic en = 1'b0;
    logic in = 1'b0;
    logic clr_cnt = 1'b0;
    logic locked;
    logic err;
    logic [CW-1:0] err_cnt;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [CW-1:0] bit_cnt;
`endif

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] g = 8'h01;  // generator history, g[k-1] = y[m-k]

    typedef struct {
        int   cyc;
        logic val;
    } lock_ev_t;

    int       err_exp_q[$];
    lock_ev_t lock_exp_q[$];
    bit       mon_on = 1'b0;
    logic     locked_prev = 1'b0;

    lfsr_checker #(
        .W(8), .POLY(9'h11D), .SYNC_CNT(16), .WIN(64), .LOSS_THR(8), .CW(CW)
    ) dut (
        .clk(clk),
        .arst(arst),
        .en(en),
        .in(in),
        .clr_cnt(clr_cnt),
        .locked(locked),
        .err(err),
`ifdef LFSR_CHECKER_BITCNT_EN
        .bit_cnt(bit_cnt),
`endif
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // y[m] = y[m-2]^y[m-3]^y[m-4]^y[m-8]
    task automatic gen_bit(output logic b);
        b = ^(g & 8'h8E);
        g = {g[6:0], b};
    endtask

    task automatic drive(input logic e, input logic v, input logic clr, output int t);
        en      = e;
        in      = v;
        clr_cnt = clr;
        t       = cyc;
        @(posedge clk);
        #1;
        en      = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic send(input logic e, input logic inv, input logic clr, output int t);
        logic b;
        if (e) begin
            gen_bit(b);
            drive(1'b1, b ^ inv, clr, t);
        end else begin
            drive(1'b0, 1'($urandom_range(1)), clr, t);
        end
    endtask

    task automatic clean(input int n);
        int t;
        for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'b0, t);
    endtask

    task automatic bad(input logic clr, output int t);
        send(1'b1, 1'b1, clr, t);
        err_exp_q.push_back(t + 1);
    endtask

    task automatic exp_lock(input int c, input logic v);
        lock_ev_t ev;
        ev.cyc = c;
        ev.val = v;
        lock_exp_q.push_back(ev);
    endtask

    task automatic do_reset(input logic was_locked);
        arst = 1'b1;
        if (was_locked) exp_lock(cyc + 1, 1'b0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        g    = 8'h01;
    endtask

    task automatic drained(input string name);
        check({name, "_pending_err"}, err_exp_q.size(), 0);
        check({name, "_pending_lock"}, lock_exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (err !== 1'b0) begin
                n_tests++;
                if (err_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL err_unexpected: err=%b at cycle %0d, expected 0", err, cyc);
                end else begin
                    int c;
                    c = err_exp_q.pop_front();
                    if (c != cyc) begin
                        n_fail++;
                        $display("FAIL err_timing: pulse at cycle %0d, expected cycle %0d", cyc, c);
                    end
                end
            end
            if (locked !== locked_prev) begin
                n_tests++;
                if (lock_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL lock_unexpected: locked=%b at cycle %0d, expected %b",
                             locked, cyc, locked_prev);
                end else begin
                    lock_ev_t ev;
                    ev = lock_exp_q.pop_front();
                    if ((ev.cyc != cyc) || (ev.val !== locked)) begin
                        n_fail++;
                        $display("FAIL lock_edge: locked=%b at cycle %0d, expected %b at cycle %0d",
                                 locked, cyc, ev.val, ev.cyc);
                    end
                end
                locked_prev = locked;
            end
        end
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation still running, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k0;

        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        locked_prev = 1'b0;
        mon_on      = 1'b1;

        // Clean stream: 8 fill + 16 matches, locked visible 24 edges after the first bit.
        g  = 8'h01;
        k0 = cyc;
        exp_lock(k0 + 24, 1'b1);
        clean(10000);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_locked", locked, 1);
        drained("clean");

        // Isolated errors: flywheel keeps lock, one pulse per bad bit.
        for (int i = 0; i < 3; i++) begin
            clean(19);
            bad(1'b0, t);
        end
        clean(20);
        check("iso_err_cnt", err_cnt, 3);
        check("iso_locked", locked, 1);
        drained("iso");

        // 14 more spaced errors: 17 total saturates a 4-bit counter at 15.
        for (int i = 0; i < 14; i++) begin
            clean(19);
            bad(1'b0, t);
        end
        clean(20);
        check("sat_err_cnt", err_cnt, 15);
        check("sat_locked", locked, 1);
        drained("sat");

        // Burst of 8 errors drops lock, then relock after 8+16 clean bits.
        do_reset(1'b1);
        check("burst_rst_err_cnt", err_cnt, 0);
        k0 = cyc;
        exp_lock(k0 + 24, 1'b1);
        clean(34);
        for (int i = 0; i < 8; i++) bad(1'b0, t);
        exp_lock(t + 1, 1'b0);
        check("burst_err_cnt", err_cnt, 8);
        k0 = cyc;
        exp_lock(k0 + 24, 1'b1);
        clean(29);
        check("burst_relocked", locked, 1);
        drained("burst");

        // Constant zero input never locks.
        do_reset(1'b1);
        for (int i = 0; i < 1000; i++) drive(1'b1, 1'b0, 1'b0, t);
        check("zero_locked", locked, 0);
        check("zero_err_cnt", err_cnt, 0);
        drained("zero");

        // Alternating enable: 24 enabled bits, lock at 47 edges after the first.
        do_reset(1'b0);
        k0 = cyc;
        exp_lock(k0 + 47, 1'b1);
        for (int i = 0; i < 34; i++) begin
            send(1'b1, 1'b0, 1'b0, t);
            send(1'b0, 1'b0, 1'b0, t);
        end
        bad(1'b0, t);
        send(1'b0, 1'b0, 1'b0, t);
        send(1'b0, 1'b0, 1'b0, t);
        check("alt_err_cnt", err_cnt, 1);
        check("alt_locked", locked, 1);
        drained("alt");

        // Mid-lock reset, relock, then clear racing an error.
        do_reset(1'b1);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        k0 = cyc;
        exp_lock(k0 + 24, 1'b1);
        clean(30);
        bad(1'b0, t);
        check("pre_clr_err_cnt", err_cnt, 1);
        bad(1'b1, t);
        check("clr_vs_err_cnt", err_cnt, 0);
`ifdef LFSR_CHECKER_BITCNT_EN
        check("clr_bit_cnt", bit_cnt, 0);
        clean(5);
        check("bit_cnt_5", bit_cnt, 5);
        drive(1'b0, 1'b0, 1'b1, t);
        check("clr_idle_bit_cnt", bit_cnt, 0);
`endif
        clean(5);
        check("final_locked", locked, 1);
        drained("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
